// File: rtl/axi4_mem_pkg.sv
// Shared types and the burst legality check for the AXI4 memory responder.
`timescale 1ns/1ps
package axi4_mem_pkg;

   typedef enum logic [1:0] {FIXED = 2'd0, INCR = 2'd1, WRAP = 2'd2} burst_e;
   typedef enum logic [1:0] {OKAY = 2'd0, SLVERR = 2'd2} resp_e;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
   typedef enum logic {R_IDLE, R_DATA} rstate_e;

   // Illegal bursts are still served (as full-width INCR) but answered with SLVERR.
   function automatic logic burst_legal(input logic [1:0] burst, input logic [2:0] size,
                                        input logic [7:0] len, input logic [2:0] max_size);
      logic ok;
      ok = (burst != 2'd3) && (size <= max_size);
      if (burst == WRAP)
         ok = ok && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
      return ok;
   endfunction

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Next-beat byte address for FIXED, INCR and WRAP bursts.
`timescale 1ns/1ps
module axi4_burst_addr_gen
   import axi4_mem_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic [2:0]        size,
   input  logic [7:0]        len,
   input  logic [1:0]        burst,
   output logic [ADDR_W-1:0] next_addr
);

   logic [ADDR_W-1:0] step;
   logic [ADDR_W-1:0] mask;
   logic [ADDR_W-1:0] sum;

   always_comb begin
      step      = ADDR_W'(1) << size;
      // Wrap window is (len+1) beats, aligned to its own size.
      mask      = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
      sum       = addr + step;
      next_addr = sum;
      if (burst == FIXED)
         next_addr = addr;
      else if (burst == WRAP)
         next_addr = (addr & ~mask) | (sum & mask);
   end

endmodule

// File: rtl/axi4_mem_responder.sv
// AXI4 subordinate backed by a word array; independent single-outstanding read and write bursts.
`timescale 1ns/1ps
module axi4_mem_responder
   import axi4_mem_pkg::*;
#(
   parameter int MEM_DATA_WIDTH = 32,
   parameter int MEM_ADDR_WIDTH = 16,
   parameter int MEM_STRB_WIDTH = MEM_DATA_WIDTH / 8,
   parameter int MEM_ID_WIDTH   = 8,
   parameter int DEPTH_WORDS    = 1024
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      mem_aw_valid,
   output logic                      mem_aw_ready,
   input  logic [MEM_ID_WIDTH-1:0]   mem_aw_bits_id,
   input  logic [MEM_ADDR_WIDTH-1:0] mem_aw_bits_addr,
   input  logic [7:0]                mem_aw_bits_len,
   input  logic [2:0]                mem_aw_bits_size,
   input  logic [1:0]                mem_aw_bits_burst,
   input  logic                      mem_aw_bits_lock,
   input  logic [3:0]                mem_aw_bits_cache,
   input  logic [2:0]                mem_aw_bits_prot,
   input  logic [3:0]                mem_aw_bits_qos,
   input  logic                      mem_w_valid,
   output logic                      mem_w_ready,
   input  logic [MEM_DATA_WIDTH-1:0] mem_w_bits_data,
   input  logic [MEM_STRB_WIDTH-1:0] mem_w_bits_strb,
   input  logic                      mem_w_bits_last,
   output logic                      mem_b_valid,
   input  logic                      mem_b_ready,
   output logic [MEM_ID_WIDTH-1:0]   mem_b_bits_id,
   output logic [1:0]                mem_b_bits_resp,
   input  logic                      mem_ar_valid,
   output logic                      mem_ar_ready,
   input  logic [MEM_ID_WIDTH-1:0]   mem_ar_bits_id,
   input  logic [MEM_ADDR_WIDTH-1:0] mem_ar_bits_addr,
   input  logic [7:0]                mem_ar_bits_len,
   input  logic [2:0]                mem_ar_bits_size,
   input  logic [1:0]                mem_ar_bits_burst,
   input  logic                      mem_ar_bits_lock,
   input  logic [3:0]                mem_ar_bits_cache,
   input  logic [2:0]                mem_ar_bits_prot,
   input  logic [3:0]                mem_ar_bits_qos,
   output logic                      mem_r_valid,
   input  logic                      mem_r_ready,
   output logic [MEM_ID_WIDTH-1:0]   mem_r_bits_id,
   output logic [MEM_DATA_WIDTH-1:0] mem_r_bits_data,
   output logic [1:0]                mem_r_bits_resp,
   output logic                      mem_r_bits_last
);

   localparam int         LOG2_STRB  = $clog2(MEM_STRB_WIDTH);
   localparam int         LOG2_DEPTH = $clog2(DEPTH_WORDS);
   localparam logic [2:0] FULL_SIZE  = 3'(LOG2_STRB);

   logic [MEM_DATA_WIDTH-1:0] mem [DEPTH_WORDS];

   wstate_e                   wstate, wstate_nxt;
   logic [MEM_ID_WIDTH-1:0]   wid;
   logic [MEM_ADDR_WIDTH-1:0] waddr, wnext;
   logic [7:0]                wlen, wbeat;
   logic [2:0]                wsize;
   logic [1:0]                wburst;
   logic                      werr;
   logic                      aw_fire, w_fire, w_last_beat;

   rstate_e                   rstate, rstate_nxt;
   logic [MEM_ADDR_WIDTH-1:0] raddr, rnext;
   logic [7:0]                rlen, rbeat;
   logic [2:0]                rsize;
   logic [1:0]                rburst;
   logic                      ar_fire, r_fire, r_last_beat;

   logic unused_sideband;
   assign unused_sideband = ^{mem_aw_bits_lock, mem_aw_bits_cache, mem_aw_bits_prot, mem_aw_bits_qos,
                              mem_ar_bits_lock, mem_ar_bits_cache, mem_ar_bits_prot, mem_ar_bits_qos};

   assign aw_fire     = mem_aw_valid & mem_aw_ready;
   assign w_fire      = mem_w_valid & mem_w_ready;
   assign w_last_beat = (wbeat == wlen);
   assign ar_fire     = mem_ar_valid & mem_ar_ready;
   assign r_fire      = mem_r_valid & mem_r_ready;
   assign r_last_beat = (rbeat == rlen);

   assign mem_b_bits_id   = wid;
   assign mem_b_bits_resp = werr ? SLVERR : OKAY;

   axi4_burst_addr_gen #(.ADDR_W(MEM_ADDR_WIDTH)) u_waddr (
      .addr(waddr), .size(wsize), .len(wlen), .burst(wburst), .next_addr(wnext));

   axi4_burst_addr_gen #(.ADDR_W(MEM_ADDR_WIDTH)) u_raddr (
      .addr(raddr), .size(rsize), .len(rlen), .burst(rburst), .next_addr(rnext));

   always_ff @(posedge clk) begin
      if (rst) wstate <= W_IDLE;
      else     wstate <= wstate_nxt;
   end

   always_comb begin
      wstate_nxt   = wstate;
      mem_aw_ready = 1'b0;
      mem_w_ready  = 1'b0;
      mem_b_valid  = 1'b0;
      case (wstate)
         W_IDLE: begin
            mem_aw_ready = 1'b1;
            if (mem_aw_valid) wstate_nxt = W_DATA;
         end
         W_DATA: begin
            mem_w_ready = 1'b1;
            if (mem_w_valid && w_last_beat) wstate_nxt = W_RESP;
         end
         W_RESP: begin
            mem_b_valid = 1'b1;
            if (mem_b_ready) wstate_nxt = W_IDLE;
         end
         default: wstate_nxt = W_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wid    <= '0;
         waddr  <= '0;
         wlen   <= '0;
         wbeat  <= '0;
         wsize  <= '0;
         wburst <= '0;
         werr   <= 1'b0;
      end else if (aw_fire) begin
         wid   <= mem_aw_bits_id;
         waddr <= mem_aw_bits_addr;
         wlen  <= mem_aw_bits_len;
         wbeat <= '0;
         if (burst_legal(mem_aw_bits_burst, mem_aw_bits_size, mem_aw_bits_len, FULL_SIZE)) begin
            wsize  <= mem_aw_bits_size;
            wburst <= mem_aw_bits_burst;
            werr   <= 1'b0;
         end else begin
            wsize  <= FULL_SIZE;
            wburst <= INCR;
            werr   <= 1'b1;
         end
      end else if (w_fire) begin
         waddr <= wnext;
         wbeat <= wbeat + 8'd1;
         // Beat count follows len; a misplaced or missing last only flags the response.
         if (mem_w_bits_last != w_last_beat) werr <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_fire) begin
         for (int b = 0; b < MEM_STRB_WIDTH; b++)
            if (mem_w_bits_strb[b])
               mem[waddr[LOG2_STRB +: LOG2_DEPTH]][8*b +: 8] <= mem_w_bits_data[8*b +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) rstate <= R_IDLE;
      else     rstate <= rstate_nxt;
   end

   always_comb begin
      rstate_nxt      = rstate;
      mem_ar_ready    = 1'b0;
      mem_r_valid     = 1'b0;
      mem_r_bits_last = 1'b0;
      case (rstate)
         R_IDLE: begin
            mem_ar_ready = 1'b1;
            if (mem_ar_valid) rstate_nxt = R_DATA;
         end
         R_DATA: begin
            mem_r_valid     = 1'b1;
            mem_r_bits_last = r_last_beat;
            if (mem_r_ready && r_last_beat) rstate_nxt = R_IDLE;
         end
         default: rstate_nxt = R_IDLE;
      endcase
   end

   // Read data is registered from the array, so a same-cycle write to that word is not yet visible.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_r_bits_id   <= '0;
         mem_r_bits_data <= '0;
         mem_r_bits_resp <= '0;
         raddr           <= '0;
         rlen            <= '0;
         rbeat           <= '0;
         rsize           <= '0;
         rburst          <= '0;
      end else if (ar_fire) begin
         mem_r_bits_id   <= mem_ar_bits_id;
         mem_r_bits_data <= mem[mem_ar_bits_addr[LOG2_STRB +: LOG2_DEPTH]];
         raddr           <= mem_ar_bits_addr;
         rlen            <= mem_ar_bits_len;
         rbeat           <= '0;
         if (burst_legal(mem_ar_bits_burst, mem_ar_bits_size, mem_ar_bits_len, FULL_SIZE)) begin
            rsize           <= mem_ar_bits_size;
            rburst          <= mem_ar_bits_burst;
            mem_r_bits_resp <= OKAY;
         end else begin
            rsize           <= FULL_SIZE;
            rburst          <= INCR;
            mem_r_bits_resp <= SLVERR;
         end
      end else if (r_fire) begin
         raddr           <= rnext;
         rbeat           <= rbeat + 8'd1;
         mem_r_bits_data <= mem[rnext[LOG2_STRB +: LOG2_DEPTH]];
      end
   end

endmodule

// File: tb/tb_axi4_mem_responder.sv
// Directed bench for axi4_mem_responder with immediate-assertion checks.
`timescale 1ns/1ps
module tb_axi4_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_aw_valid, mem_aw_ready;
   logic [7:0]  mem_aw_bits_id;
   logic [15:0] mem_aw_bits_addr;
   logic [7:0]  mem_aw_bits_len;
   logic [2:0]  mem_aw_bits_size;
   logic [1:0]  mem_aw_bits_burst;
   logic        mem_w_valid, mem_w_ready;
   logic [31:0] mem_w_bits_data;
   logic [3:0]  mem_w_bits_strb;
   logic        mem_w_bits_last;
   logic        mem_b_valid, mem_b_ready;
   logic [7:0]  mem_b_bits_id;
   logic [1:0]  mem_b_bits_resp;
   logic        mem_ar_valid, mem_ar_ready;
   logic [7:0]  mem_ar_bits_id;
   logic [15:0] mem_ar_bits_addr;
   logic [7:0]  mem_ar_bits_len;
   logic [2:0]  mem_ar_bits_size;
   logic [1:0]  mem_ar_bits_burst;
   logic        mem_r_valid, mem_r_ready;
   logic [7:0]  mem_r_bits_id;
   logic [31:0] mem_r_bits_data;
   logic [1:0]  mem_r_bits_resp;
   logic        mem_r_bits_last;

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [31:0] wd [16];
   logic [3:0]  ws [16];
   logic [31:0] ex [16];

   localparam logic [1:0] BF = 2'd0, BI = 2'd1, BW = 2'd2;
   localparam logic [1:0] OK = 2'd0, SE = 2'd2;

   always #5 clk = ~clk;

   axi4_mem_responder dut (
      .clk(clk), .rst(rst),
      .mem_aw_valid(mem_aw_valid), .mem_aw_ready(mem_aw_ready),
      .mem_aw_bits_id(mem_aw_bits_id), .mem_aw_bits_addr(mem_aw_bits_addr),
      .mem_aw_bits_len(mem_aw_bits_len), .mem_aw_bits_size(mem_aw_bits_size),
      .mem_aw_bits_burst(mem_aw_bits_burst), .mem_aw_bits_lock(1'b0),
      .mem_aw_bits_cache(4'd0), .mem_aw_bits_prot(3'd0), .mem_aw_bits_qos(4'd0),
      .mem_w_valid(mem_w_valid), .mem_w_ready(mem_w_ready),
      .mem_w_bits_data(mem_w_bits_data), .mem_w_bits_strb(mem_w_bits_strb),
      .mem_w_bits_last(mem_w_bits_last),
      .mem_b_valid(mem_b_valid), .mem_b_ready(mem_b_ready),
      .mem_b_bits_id(mem_b_bits_id), .mem_b_bits_resp(mem_b_bits_resp),
      .mem_ar_valid(mem_ar_valid), .mem_ar_ready(mem_ar_ready),
      .mem_ar_bits_id(mem_ar_bits_id), .mem_ar_bits_addr(mem_ar_bits_addr),
      .mem_ar_bits_len(mem_ar_bits_len), .mem_ar_bits_size(mem_ar_bits_size),
      .mem_ar_bits_burst(mem_ar_bits_burst), .mem_ar_bits_lock(1'b0),
      .mem_ar_bits_cache(4'd0), .mem_ar_bits_prot(3'd0), .mem_ar_bits_qos(4'd0),
      .mem_r_valid(mem_r_valid), .mem_r_ready(mem_r_ready),
      .mem_r_bits_id(mem_r_bits_id), .mem_r_bits_data(mem_r_bits_data),
      .mem_r_bits_resp(mem_r_bits_resp), .mem_r_bits_last(mem_r_bits_last)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic aw_send(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      int cyc = 0;
      mem_aw_valid = 1'b1; mem_aw_bits_id = id; mem_aw_bits_addr = addr;
      mem_aw_bits_len = len; mem_aw_bits_size = size; mem_aw_bits_burst = burst;
      while (!mem_aw_ready && cyc < 50) begin @(negedge clk); cyc++; end
      if (!mem_aw_ready) chk("aw_timeout", 64'd0, 64'd1);
      @(posedge clk); #1 mem_aw_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic ar_send(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      int cyc = 0;
      mem_ar_valid = 1'b1; mem_ar_bits_id = id; mem_ar_bits_addr = addr;
      mem_ar_bits_len = len; mem_ar_bits_size = size; mem_ar_bits_burst = burst;
      while (!mem_ar_ready && cyc < 50) begin @(negedge clk); cyc++; end
      if (!mem_ar_ready) chk("ar_timeout", 64'd0, 64'd1);
      @(posedge clk); #1 mem_ar_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic w_send(input int n, input int last_at);
      for (int i = 0; i < n; i++) begin
         int cyc = 0;
         mem_w_valid = 1'b1; mem_w_bits_data = wd[i]; mem_w_bits_strb = ws[i];
         mem_w_bits_last = (i == last_at);
         while (!mem_w_ready && cyc < 50) begin @(negedge clk); cyc++; end
         if (!mem_w_ready) chk("w_timeout", 64'd0, 64'd1);
         @(posedge clk); #1;
      end
      mem_w_valid = 1'b0; mem_w_bits_last = 1'b0;
      @(negedge clk);
   endtask

   task automatic b_recv(input string tag, input logic [7:0] id, input logic [1:0] resp, input int stall);
      int cyc = 0;
      while (!mem_b_valid && cyc < 50) begin @(negedge clk); cyc++; end
      chk({tag, "_bvalid"}, 64'(mem_b_valid), 64'd1);
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         chk({tag, "_bhold"}, {mem_b_valid, mem_b_bits_id, mem_b_bits_resp}, {1'b1, id, resp});
      end
      chk({tag, "_bid"}, 64'(mem_b_bits_id), 64'(id));
      chk({tag, "_bresp"}, 64'(mem_b_bits_resp), 64'(resp));
      mem_b_ready = 1'b1;
      @(posedge clk); #1 mem_b_ready = 1'b0;
      chk({tag, "_aw_back"}, {mem_aw_ready, mem_b_valid}, 64'b10);
      @(negedge clk);
   endtask

   task automatic r_recv(input string tag, input logic [7:0] id, input int n, input logic [1:0] resp,
                         input bit stall);
      for (int i = 0; i < n; i++) begin
         int cyc = 0;
         while (!mem_r_valid && cyc < 50) begin @(negedge clk); cyc++; end
         chk({tag, "_rvalid"}, 64'(mem_r_valid), 64'd1);
         if (stall) begin
            logic [43:0] snap;
            int k;
            snap = {mem_r_valid, mem_r_bits_data, mem_r_bits_id, mem_r_bits_resp, mem_r_bits_last};
            k = $urandom_range(1, 3);
            for (int s = 0; s < k; s++) begin
               @(negedge clk);
               chk({tag, "_rhold"},
                   {mem_r_valid, mem_r_bits_data, mem_r_bits_id, mem_r_bits_resp, mem_r_bits_last}, snap);
            end
         end
         chk($sformatf("%s_data%0d", tag, i), 64'(mem_r_bits_data), 64'(ex[i]));
         chk($sformatf("%s_last%0d", tag, i), 64'(mem_r_bits_last), 64'(i == n - 1));
         chk($sformatf("%s_id%0d", tag, i), {mem_r_bits_id, mem_r_bits_resp}, {id, resp});
         mem_r_ready = 1'b1;
         @(posedge clk); #1 mem_r_ready = 1'b0;
      end
      chk({tag, "_ar_back"}, {mem_ar_ready, mem_r_valid}, 64'b10);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired before end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      mem_aw_valid = 0; mem_aw_bits_id = 0; mem_aw_bits_addr = 0; mem_aw_bits_len = 0;
      mem_aw_bits_size = 0; mem_aw_bits_burst = 0;
      mem_w_valid = 0; mem_w_bits_data = 0; mem_w_bits_strb = 0; mem_w_bits_last = 0;
      mem_b_ready = 0;
      mem_ar_valid = 0; mem_ar_bits_id = 0; mem_ar_bits_addr = 0; mem_ar_bits_len = 0;
      mem_ar_bits_size = 0; mem_ar_bits_burst = 0;
      mem_r_ready = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);

      chk("rst_ready", {mem_aw_ready, mem_ar_ready, mem_w_ready}, 64'b110);
      chk("rst_valid", {mem_b_valid, mem_r_valid, mem_r_bits_last}, 64'b000);
      chk("rst_ids", {mem_b_bits_id, mem_r_bits_id, mem_b_bits_resp, mem_r_bits_resp}, 64'd0);
      chk("rst_rdata", 64'(mem_r_bits_data), 64'd0);

      // Single-beat INCR write and readback.
      wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
      aw_send(8'h05, 16'h0010, 8'd0, 3'd2, BI); w_send(1, 0); b_recv("single", 8'h05, OK, 0);
      ex[0] = 32'hDEADBEEF;
      ar_send(8'h06, 16'h0010, 8'd0, 3'd2, BI); r_recv("single_rd", 8'h06, 1, OK, 1'b0);

      // Four-beat INCR with delayed b_ready.
      for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; ex[i] = 32'(i + 1); end
      aw_send(8'h11, 16'h0020, 8'd3, 3'd2, BI); w_send(4, 3); b_recv("incr4", 8'h11, OK, 2);
      ar_send(8'h12, 16'h0020, 8'd3, 3'd2, BI); r_recv("incr4_rd", 8'h12, 4, OK, 1'b0);

      // WRAP from 0x38 lands at 38,3C,30,34.
      for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
      aw_send(8'h13, 16'h0038, 8'd3, 3'd2, BW); w_send(4, 3); b_recv("wrap", 8'h13, OK, 0);
      ex[0] = 32'hA2; ex[1] = 32'hA3; ex[2] = 32'hA0; ex[3] = 32'hA1;
      ar_send(8'h14, 16'h0030, 8'd3, 3'd2, BI); r_recv("wrap_rd_incr", 8'h14, 4, OK, 1'b0);
      for (int i = 0; i < 4; i++) ex[i] = 32'hA0 + 32'(i);
      ar_send(8'h15, 16'h0038, 8'd3, 3'd2, BW); r_recv("wrap_rd_wrap", 8'h15, 4, OK, 1'b0);

      // FIXED: every beat hits 0x40, last one wins.
      for (int i = 0; i < 4; i++) begin wd[i] = 32'hB0 + 32'(i); ws[i] = 4'hF; end
      aw_send(8'h16, 16'h0040, 8'd3, 3'd2, BF); w_send(4, 3); b_recv("fixed", 8'h16, OK, 0);
      ex[0] = 32'hB3;
      ar_send(8'h17, 16'h0040, 8'd0, 3'd2, BI); r_recv("fixed_rd", 8'h17, 1, OK, 1'b0);

      // Strobes: 0x5 enables bytes 0 and 2, 0x4 only byte 2.
      wd[0] = 32'h11223344; ws[0] = 4'hF; wd[1] = 32'h11223344; ws[1] = 4'hF;
      aw_send(8'h18, 16'h0050, 8'd1, 3'd2, BI); w_send(2, 1); b_recv("strb_init", 8'h18, OK, 0);
      wd[0] = 32'hAABBCCDD; ws[0] = 4'h5; wd[1] = 32'hAABBCCDD; ws[1] = 4'h4;
      aw_send(8'h19, 16'h0050, 8'd1, 3'd2, BI); w_send(2, 1); b_recv("strb", 8'h19, OK, 0);
      ex[0] = 32'h11BB33DD; ex[1] = 32'h11BB3344;
      ar_send(8'h1A, 16'h0050, 8'd1, 3'd2, BI); r_recv("strb_rd", 8'h1A, 2, OK, 1'b0);

      // Early w_last: all four beats still taken and written, response SLVERR.
      for (int i = 0; i < 4; i++) begin wd[i] = 32'hD0 + 32'(i); ws[i] = 4'hF; ex[i] = wd[i]; end
      aw_send(8'h22, 16'h0080, 8'd3, 3'd2, BI); w_send(4, 1); b_recv("early_last", 8'h22, SE, 0);
      ar_send(8'h23, 16'h0080, 8'd3, 3'd2, BI); r_recv("early_last_rd", 8'h23, 4, OK, 1'b0);

      // Reserved burst on AR serves as INCR with SLVERR on every beat.
      ex[0] = 32'd1; ex[1] = 32'd2;
      ar_send(8'h77, 16'h0020, 8'd1, 3'd2, 2'd3); r_recv("rsvd_rd", 8'h77, 2, SE, 1'b0);

      // Address beyond DEPTH aliases onto word 4 (0x10).
      wd[0] = 32'h5A5A1234; ws[0] = 4'hF; ex[0] = 32'h5A5A1234;
      aw_send(8'h24, 16'h1010, 8'd0, 3'd2, BI); w_send(1, 0); b_recv("alias", 8'h24, OK, 0);
      ar_send(8'h25, 16'h0010, 8'd0, 3'd2, BI); r_recv("alias_rd", 8'h25, 1, OK, 1'b0);

      // Read backpressure with random stalls.
      for (int i = 0; i < 4; i++) ex[i] = 32'(i + 1);
      ar_send(8'h26, 16'h0020, 8'd3, 3'd2, BI); r_recv("stall_rd", 8'h26, 4, OK, 1'b1);

      // Reset in the middle of both a write and a read burst.
      wd[0] = 32'hC0; wd[1] = 32'hC1; ws[0] = 4'hF; ws[1] = 4'hF;
      aw_send(8'h33, 16'h0070, 8'd3, 3'd2, BI); w_send(2, 3);
      ar_send(8'h44, 16'h0020, 8'd3, 3'd2, BI);
      chk("midrst_rvalid_pre", 64'(mem_r_valid), 64'd1);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      chk("midrst_ready", {mem_aw_ready, mem_ar_ready, mem_w_ready}, 64'b110);
      chk("midrst_valid", {mem_b_valid, mem_r_valid, mem_r_bits_last}, 64'b000);
      repeat (2) @(negedge clk);
      chk("midrst_quiet", {mem_b_valid, mem_r_valid}, 64'b00);
      ex[0] = 32'hC0; ex[1] = 32'hC1;
      ar_send(8'h45, 16'h0070, 8'd1, 3'd2, BI); r_recv("midrst_rd", 8'h45, 2, OK, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
